// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: shares the VGA adapter plot port between NREQ pixel writers.
// Round-robin, burst-locked grants with an optional per-grant beat limit, plus a
// built-in full-screen clear engine that sweeps SCR_W x SCR_H pixels in one colour.
module vga_plot_arbiter #(
  parameter int unsigned NREQ      = 3,
  parameter int unsigned MAX_BURST = 0,
  parameter int unsigned SCR_W     = 160,
  parameter int unsigned SCR_H     = 120
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   gnt,
  input  logic [NREQ*8-1:0] x_in,
  input  logic [NREQ*7-1:0] y_in,
  input  logic [NREQ*3-1:0] colour_in,
  input  logic [NREQ-1:0]   plot_in,
  input  logic              clr_start,
  input  logic [2:0]        clr_colour,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [7:0]        vga_x,
  output logic [6:0]        vga_y,
  output logic [2:0]        vga_colour,
  output logic              vga_plot
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StGrant = 2'd1;
  localparam logic [1:0] StClear = 2'd2;

  localparam logic [7:0]  XLast     = 8'(SCR_W - 1);
  localparam logic [6:0]  YLast     = 7'(SCR_H - 1);
  localparam bit          BurstLim  = (MAX_BURST != 0);
  // Only meaningful when BurstLim is set; guarded to avoid an underflowed constant.
  localparam logic [15:0] BurstLast = (MAX_BURST == 0) ? 16'd0 : 16'(MAX_BURST - 1);

  logic [1:0]      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [PtrW-1:0] gidx_q, gidx_d;
  logic [PtrW-1:0] rr_q, rr_d;
  logic [15:0]     burst_q, burst_d;
  logic            pend_q, pend_d;
  logic [2:0]      ccol_q, ccol_d;
  logic [7:0]      cx_q, cx_d;
  logic [6:0]      cy_q, cy_d;
  logic            done_q, done_d;

  logic            pick_valid;
  logic [PtrW-1:0] pick_idx;
  logic [PtrW-1:0] cand_idx;
  int unsigned     cand;
  logic            burst_exit;

  // Round-robin search: first asserted request at or after rr_q, wrapping modulo NREQ.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = 32'(rr_q) + i;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      cand_idx = PtrW'(cand);
      if (!pick_valid && req[cand_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // A burst ends when the owner drops req or the last allowed beat is reached.
  always_comb begin
    burst_exit = !req[gidx_q];
    if (BurstLim && (burst_q == BurstLast)) begin
      burst_exit = 1'b1;
    end
  end

  // Next-state logic for the arbiter FSM, burst counter and clear engine.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    gidx_d  = gidx_q;
    rr_d    = rr_q;
    burst_d = burst_q;
    pend_d  = pend_q;
    ccol_d  = ccol_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    done_d  = 1'b0;

    // A new clear request is only accepted when none is pending or running, so
    // the latched colour cannot change underneath an active sweep.
    if ((state_q != StClear) && !pend_q && clr_start) begin
      pend_d = 1'b1;
      ccol_d = clr_colour;
    end

    case (state_q)
      StIdle: begin
        if (pend_q) begin
          state_d = StClear;
          cx_d    = '0;
          cy_d    = '0;
        end else if (pick_valid) begin
          state_d = StGrant;
          gnt_d   = NREQ'(1) << pick_idx;
          gidx_d  = pick_idx;
          burst_d = '0;
        end
      end

      StGrant: begin
        if (burst_exit) begin
          state_d = StIdle;
          gnt_d   = '0;
          rr_d    = (gidx_q == PtrW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
        end else if (burst_q != 16'hFFFF) begin
          burst_d = burst_q + 16'd1;
        end
      end

      StClear: begin
        if (cx_q == XLast) begin
          cx_d = '0;
          if (cy_q == YLast) begin
            cy_d    = '0;
            state_d = StIdle;
            pend_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            cy_d = cy_q + 7'd1;
          end
        end else begin
          cx_d = cx_q + 8'd1;
        end
      end

      default: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      gidx_q  <= '0;
      rr_q    <= '0;
      burst_q <= '0;
      pend_q  <= 1'b0;
      ccol_q  <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      gidx_q  <= gidx_d;
      rr_q    <= rr_d;
      burst_q <= burst_d;
      pend_q  <= pend_d;
      ccol_q  <= ccol_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      done_q  <= done_d;
    end
  end

  // Adapter port mux: zero-latency pass-through of the granted slice, or the sweep.
  always_comb begin
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    vga_plot   = 1'b0;
    case (state_q)
      StGrant: begin
        vga_x      = x_in[8*gidx_q +: 8];
        vga_y      = y_in[7*gidx_q +: 7];
        vga_colour = colour_in[3*gidx_q +: 3];
        vga_plot   = plot_in[gidx_q] & req[gidx_q];
      end
      StClear: begin
        vga_x      = cx_q;
        vga_y      = cy_q;
        vga_colour = ccol_q;
        vga_plot   = 1'b1;
      end
      default: begin
        vga_plot = 1'b0;
      end
    endcase
  end

  assign gnt      = gnt_q;
  assign clr_busy = pend_q;
  assign clr_done = done_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed bench for vga_plot_arbiter: reset, single grant, round-robin, burst
// limit (second instance with MAX_BURST=4), clear during grant, reset mid-clear.
module tb_vga_plot_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  req;
  logic [2:0]  gnt;
  logic [23:0] x_in;
  logic [20:0] y_in;
  logic [8:0]  colour_in;
  logic [2:0]  plot_in;
  logic        clr_start;
  logic [2:0]  clr_colour;
  logic        clr_busy;
  logic        clr_done;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;

  logic [2:0]  req_m;
  logic [2:0]  gnt_m;
  logic [23:0] x_in_m;
  logic [20:0] y_in_m;
  logic [8:0]  colour_in_m;
  logic [2:0]  plot_in_m;
  logic        clr_start_m;
  logic [2:0]  clr_colour_m;
  logic        clr_busy_m;
  logic        clr_done_m;
  logic [7:0]  vga_x_m;
  logic [6:0]  vga_y_m;
  logic [2:0]  vga_colour_m;
  logic        vga_plot_m;

  int pass_cnt  = 0;
  int total_cnt = 0;

  vga_plot_arbiter #(.NREQ(3), .MAX_BURST(0), .SCR_W(160), .SCR_H(120)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .x_in(x_in), .y_in(y_in),
    .colour_in(colour_in), .plot_in(plot_in), .clr_start(clr_start),
    .clr_colour(clr_colour), .clr_busy(clr_busy), .clr_done(clr_done),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  vga_plot_arbiter #(.NREQ(3), .MAX_BURST(4), .SCR_W(160), .SCR_H(120)) dut_m (
    .clk(clk), .rst(rst), .req(req_m), .gnt(gnt_m), .x_in(x_in_m), .y_in(y_in_m),
    .colour_in(colour_in_m), .plot_in(plot_in_m), .clr_start(clr_start_m),
    .clr_colour(clr_colour_m), .clr_busy(clr_busy_m), .clr_done(clr_done_m),
    .vga_x(vga_x_m), .vga_y(vga_y_m), .vga_colour(vga_colour_m), .vga_plot(vga_plot_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    int bad;
    int w;
    int done_seen;
    rst = 1'b1; req = '0; x_in = '0; y_in = '0; colour_in = '0; plot_in = '0;
    clr_start = 1'b0; clr_colour = '0;
    req_m = '0; x_in_m = '0; y_in_m = '0; colour_in_m = '0; plot_in_m = '0;
    clr_start_m = 1'b0; clr_colour_m = '0;

    // Reset then idle
    cyc(); cyc();
    check("rst_gnt", gnt, 0);
    check("rst_plot", vga_plot, 0);
    check("rst_x", vga_x, 0);
    check("rst_busy", clr_busy, 0);
    check("rst_done", clr_done, 0);
    check("rst_gnt_m", gnt_m, 0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("idle_gnt", gnt, 0);
      check("idle_plot", vga_plot, 0);
      check("idle_busy", clr_busy, 0);
    end

    // Single requester 1: (20,15,010); other slices hold distinct values
    x_in = {8'd99, 8'd20, 8'd5};
    y_in = {7'd44, 7'd15, 7'd3};
    colour_in = {3'b111, 3'b010, 3'b001};
    plot_in = 3'b010;
    req = 3'b010;
    #1;
    check("single_no_gnt_yet", gnt, 0);
    check("single_no_plot_yet", vga_plot, 0);
    cyc();
    check("single_gnt", gnt, 3'b010);
    check("single_plot", vga_plot, 1);
    check("single_x", vga_x, 20);
    check("single_y", vga_y, 15);
    check("single_col", vga_colour, 3'b010);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("single_gnt_hold", gnt, 3'b010);
      check("single_plot_hold", vga_plot, 1);
    end
    req = 3'b000;
    #1;
    check("single_plot_req_low", vga_plot, 0);
    check("single_gnt_req_low", gnt, 3'b010);
    cyc();
    check("single_gnt_drop", gnt, 0);
    check("single_plot_idle", vga_plot, 0);
    plot_in = 3'b000;

    // Round-robin from a fresh pointer: order 0,1,2,0 with a bubble each time
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      w = k % 3;
      cyc();
      check("rr_gnt", gnt, 1 << w);
      cyc(); cyc();
      check("rr_gnt_hold", gnt, 1 << w);
      req[w] = 1'b0;
      cyc();
      check("rr_bubble", gnt, 0);
      if (k < 3) req[w] = 1'b1;
    end
    req = 3'b000;

    // MAX_BURST=4 instance: req 0 and 2 high
    req_m = 3'b101;
    cyc();
    check("mb_gnt0", gnt_m, 3'b001);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("mb_gnt0_hold", gnt_m, 3'b001);
    end
    cyc();
    check("mb_bubble", gnt_m, 0);
    cyc();
    check("mb_gnt2", gnt_m, 3'b100);
    req_m = 3'b000;
    cyc();
    check("mb_release", gnt_m, 0);

    // Clear during a grant to requester 0 (pointer is at 1, only req 0 asserted)
    req = 3'b001;
    cyc();
    check("clr_gnt0", gnt, 3'b001);
    clr_start = 1'b1;
    clr_colour = 3'b000;
    req = 3'b011;
    cyc();
    clr_start = 1'b0;
    check("clr_busy_next", clr_busy, 1);
    check("clr_no_preempt", gnt, 3'b001);
    req = 3'b010;
    cyc();
    check("clr_wait_idle_gnt", gnt, 0);
    check("clr_wait_idle_plot", vga_plot, 0);
    check("clr_wait_busy", clr_busy, 1);
    cyc();
    bad = 0;
    for (int p = 0; p < 19200; p++) begin
      if (p == 0) begin
        check("clr_first_x", vga_x, 0);
        check("clr_first_y", vga_y, 0);
        check("clr_first_plot", vga_plot, 1);
      end
      if (p == 19199) begin
        check("clr_last_x", vga_x, 159);
        check("clr_last_y", vga_y, 119);
      end
      if (vga_x !== 8'(p % 160) || vga_y !== 7'(p / 160) || vga_plot !== 1'b1 ||
          vga_colour !== 3'b000 || gnt !== 3'b000 || clr_done !== 1'b0 ||
          clr_busy !== 1'b1) begin
        bad++;
      end
      // A second request mid-sweep must neither restart nor recolour it.
      if (p == 100) begin
        clr_start = 1'b1;
        clr_colour = 3'b111;
      end
      if (p == 101) clr_start = 1'b0;
      cyc();
    end
    check("clr_sweep_errors", bad, 0);
    check("clr_done_pulse", clr_done, 1);
    check("clr_busy_cleared", clr_busy, 0);
    check("clr_end_plot", vga_plot, 0);
    check("clr_end_gnt", gnt, 0);
    cyc();
    check("clr_done_one_cycle", clr_done, 0);
    check("clr_then_gnt1", gnt, 3'b010);
    req = 3'b000;
    cyc(); cyc();

    // Reset in the middle of a sweep
    clr_colour = 3'b101;
    clr_start = 1'b1;
    cyc();
    clr_start = 1'b0;
    cyc();
    for (int i = 0; i < 9680; i++) cyc();
    check("mid_x", vga_x, 80);
    check("mid_y", vga_y, 60);
    check("mid_col", vga_colour, 3'b101);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("mid_rst_plot", vga_plot, 0);
    check("mid_rst_x", vga_x, 0);
    check("mid_rst_y", vga_y, 0);
    check("mid_rst_col", vga_colour, 0);
    check("mid_rst_busy", clr_busy, 0);
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (clr_done === 1'b1 || vga_plot !== 1'b0) done_seen++;
    end
    check("mid_rst_quiet", done_seen, 0);
    clr_colour = 3'b110;
    clr_start = 1'b1;
    cyc();
    clr_start = 1'b0;
    check("restart_busy", clr_busy, 1);
    cyc();
    check("restart_x", vga_x, 0);
    check("restart_y", vga_y, 0);
    check("restart_plot", vga_plot, 1);
    check("restart_col", vga_colour, 3'b110);
    cyc();
    check("restart_x1", vga_x, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
